// File: rtl/mealy_word_collector.sv
`default_nettype none
// ============================================================================
//  Module   : mealy_word_collector
//  Purpose  : Assembles WIDTH serial bits (strobe R, value Y) from the Mealy
//             S/D decoder into a parallel word and hands it downstream over a
//             Valid/Ready handshake. It also flags dropped words (Overrun)
//             and partial words abandoned after an inter-bit idle period
//             (TimeoutErr) so that system control can resynchronise the link.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    bits per assembled word (2..32)
//    TIMEOUT  idle cycles allowed between bits of one word; 0 disables
//    TW       timer width, 2**TW > TIMEOUT
//  Ports
//    C           in   1       clock, rising edge
//    sR          in   1       synchronous reset, active-high
//    R           in   1       bit strobe, one bit accepted per high cycle
//    Y           in   1       bit value, only looked at when R=1
//    Ready       in   1       downstream accepts Word this cycle
//    Word        out  WIDTH   assembled word, stable while Valid=1
//    Valid       out  1       Word holds an unconsumed word
//    BitCnt      out  clog2+1 bits in the current partial word
//    Overrun     out  1       sticky: a completed word was dropped
//    TimeoutErr  out  1       one-cycle pulse: a partial word was discarded
//  Build option
//    MEALY_COLLECT_MSB_FIRST_EN  defined: MSB-first assembly (first bit ends
//                                in Word[WIDTH-1]); undefined: LSB-first.
// ============================================================================
module mealy_word_collector #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input  logic                     C,
   input  logic                     sR,
   input  logic                     R,
   input  logic                     Y,
   input  logic                     Ready,
   output logic [WIDTH-1:0]         Word,
   output logic                     Valid,
   output logic [$clog2(WIDTH):0]   BitCnt,
   output logic                     Overrun,
   output logic                     TimeoutErr
);

   localparam int BW = $clog2(WIDTH) + 1;

   // Count value at which the next accepted bit completes the word.
   localparam logic [BW-1:0] c_lastCnt  = BW'(WIDTH - 1);
   localparam logic [BW-1:0] c_oneCnt   = BW'(1);
   // Timeout fires on the idle edge that would bring the timer to TIMEOUT.
   localparam logic          c_toEn     = (TIMEOUT != 0);
   localparam logic [TW-1:0] c_toLast   = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [TW-1:0] c_timerOne = TW'(1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_e;

   state_e            r_state,      w_stateNext;
   logic [WIDTH-1:0]  r_shiftReg,   w_shiftNext;
   logic [BW-1:0]     r_bitCnt,     w_bitCntNext;
   logic [TW-1:0]     r_timer,      w_timerNext;
   logic [WIDTH-1:0]  r_word,       w_wordNext;
   logic              r_valid,      w_validNext;
   logic              r_overrun,    w_overrunNext;
   logic              r_timeoutErr, w_timeoutNext;

   logic [WIDTH-1:0]  w_shifted;
   logic              w_complete;
   logic              w_xfer;

   // Shift register contents with Y inserted. Only registered on edges where
   // R=1, so an X on Y while R=0 never reaches state.
`ifdef MEALY_COLLECT_MSB_FIRST_EN
   assign w_shifted = {r_shiftReg[WIDTH-2:0], Y};
`else
   assign w_shifted = {Y, r_shiftReg[WIDTH-1:1]};
`endif

   assign w_xfer = r_valid & Ready;

   // ------------------------------------------------------------------
   // Next-state, collection datapath and output-register handshake
   // ------------------------------------------------------------------
   always_comb begin
      w_stateNext   = r_state;
      w_shiftNext   = r_shiftReg;
      w_bitCntNext  = r_bitCnt;
      w_timerNext   = r_timer;
      w_wordNext    = r_word;
      w_validNext   = r_valid;
      w_overrunNext = r_overrun;
      w_timeoutNext = 1'b0;
      w_complete    = 1'b0;

      case (r_state)
         IDLE: begin
            // Timer is idle here; it only runs inside a partial word.
            w_timerNext = '0;
            if (R) begin
               w_shiftNext  = w_shifted;
               w_bitCntNext = c_oneCnt;
               w_stateNext  = COLLECT;
            end
         end

         COLLECT: begin
            if (R) begin
               w_timerNext = '0;
               if (r_bitCnt == c_lastCnt) begin
                  // Last bit: the finished word is w_shifted itself.
                  w_complete   = 1'b1;
                  w_shiftNext  = '0;
                  w_bitCntNext = '0;
                  w_stateNext  = IDLE;
               end else begin
                  w_shiftNext  = w_shifted;
                  w_bitCntNext = r_bitCnt + c_oneCnt;
               end
            end else if (c_toEn && (r_timer == c_toLast)) begin
               w_shiftNext   = '0;
               w_bitCntNext  = '0;
               w_timerNext   = '0;
               w_timeoutNext = 1'b1;
               w_stateNext   = IDLE;
            end else if (c_toEn) begin
               w_timerNext = r_timer + c_timerOne;
            end
         end

         default: begin
            w_stateNext  = IDLE;
            w_shiftNext  = '0;
            w_bitCntNext = '0;
            w_timerNext  = '0;
         end
      endcase

      // A completed word may take the output register when it is empty or
      // is being emptied on this very edge; otherwise the new word is lost.
      if (w_complete && (!r_valid || w_xfer)) begin
         w_wordNext  = w_shifted;
         w_validNext = 1'b1;
      end else if (w_complete) begin
         w_overrunNext = 1'b1;
      end else if (w_xfer) begin
         w_validNext = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge C) begin
      if (sR) begin
         r_state      <= IDLE;
         r_shiftReg   <= '0;
         r_bitCnt     <= '0;
         r_timer      <= '0;
         r_word       <= '0;
         r_valid      <= 1'b0;
         r_overrun    <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_shiftReg   <= w_shiftNext;
         r_bitCnt     <= w_bitCntNext;
         r_timer      <= w_timerNext;
         r_word       <= w_wordNext;
         r_valid      <= w_validNext;
         r_overrun    <= w_overrunNext;
         r_timeoutErr <= w_timeoutNext;
      end
   end

   assign Word       = r_word;
   assign Valid      = r_valid;
   assign BitCnt     = r_bitCnt;
   assign Overrun    = r_overrun;
   assign TimeoutErr = r_timeoutErr;

endmodule
`default_nettype wire

// File: tb/tb_mealy_word_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mealy_word_collector
//  Purpose  : Self-checking bench for mealy_word_collector. A queue-based
//             reference model tracks collected bits, idle time, the held
//             word and the error flags; every cycle all outputs are compared.
//             Directed scenarios are followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_word_collector;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int TW      = 5;
   localparam int BW      = $clog2(WIDTH) + 1;

   logic              C = 1'b0;
   logic              sR = 1'b1;
   logic              R = 1'b0;
   logic              Y = 1'b0;
   logic              Ready = 1'b0;
   logic [WIDTH-1:0]  Word;
   logic              Valid;
   logic [BW-1:0]     BitCnt;
   logic              Overrun;
   logic              TimeoutErr;

   mealy_word_collector #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .C          (C),
      .sR         (sR),
      .R          (R),
      .Y          (Y),
      .Ready      (Ready),
      .Word       (Word),
      .Valid      (Valid),
      .BitCnt     (BitCnt),
      .Overrun    (Overrun),
      .TimeoutErr (TimeoutErr)
   );

   always #5 C = ~C;

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   bit               mBits[$];
   int               mIdle    = 0;
   logic [WIDTH-1:0] mWord    = '0;
   logic             mValid   = 1'b0;
   logic             mOverrun = 1'b0;
   logic             mToErr   = 1'b0;

   task automatic modelStep(input logic rst, input logic r, input logic y, input logic rdy);
      logic             xfer;
      logic             done;
      logic [WIDTH-1:0] w;
      xfer   = mValid && rdy;
      done   = 1'b0;
      w      = '0;
      mToErr = 1'b0;
      if (rst) begin
         mBits.delete();
         mIdle    = 0;
         mWord    = '0;
         mValid   = 1'b0;
         mOverrun = 1'b0;
         return;
      end
      if (r) begin
         mBits.push_back(y);
         mIdle = 0;
         if (mBits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) begin
`ifdef MEALY_COLLECT_MSB_FIRST_EN
               w[WIDTH-1-i] = mBits[i];
`else
               w[i] = mBits[i];
`endif
            end
            done = 1'b1;
            mBits.delete();
         end
      end else if (mBits.size() > 0) begin
         mIdle++;
         if (TIMEOUT != 0 && mIdle == TIMEOUT) begin
            mBits.delete();
            mIdle  = 0;
            mToErr = 1'b1;
         end
      end
      if (done && (!mValid || xfer)) begin
         mWord  = w;
         mValid = 1'b1;
      end else if (done) begin
         mOverrun = 1'b1;
      end else if (xfer) begin
         mValid = 1'b0;
      end
   endtask

   // One clock: drive inputs, step model on the edge, compare 1 ns later.
   task automatic tick(input logic rst, input logic r, input logic y, input logic rdy);
      sR    = rst;
      R     = r;
      Y     = r ? y : 1'bx;
      Ready = rdy;
      @(posedge C);
      modelStep(rst, r, y, rdy);
      #1;
      check("Word",       32'(Word),       32'(mWord));
      check("Valid",      32'(Valid),      32'(mValid));
      check("BitCnt",     32'(BitCnt),     32'(mBits.size()));
      check("Overrun",    32'(Overrun),    32'(mOverrun));
      check("TimeoutErr", 32'(TimeoutErr), 32'(mToErr));
   endtask

   // Feeds a word so that it reads back as w in either bit-order build.
   task automatic sendWord(input logic [WIDTH-1:0] w, input int gap, input logic rdy);
      logic b;
      for (int i = 0; i < WIDTH; i++) begin
`ifdef MEALY_COLLECT_MSB_FIRST_EN
         b = w[WIDTH-1-i];
`else
         b = w[i];
`endif
         tick(1'b0, 1'b1, b, rdy);
         if (i < WIDTH - 1) repeat (gap) tick(1'b0, 1'b0, 1'b0, rdy);
      end
   endtask

   initial begin
      // Reset state
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_word",  32'(Word),  32'h0);
      check("rst_valid", 32'(Valid), 32'h0);

      // Contiguous word A5, Ready held high
      sendWord(8'hA5, 0, 1'b1);
      check("a5_word",  32'(Word),  32'hA5);
      check("a5_valid", 32'(Valid), 32'h1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_taken", 32'(Valid), 32'h0);

      // Bits separated by two idle cycles, no timeout
      sendWord(8'h3C, 2, 1'b1);
      check("gap_word", 32'(Word),       32'h3C);
      check("gap_to",   32'(TimeoutErr), 32'h0);

      // Three bits then 16 idle cycles -> timeout
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         if (k == 15) check("to_early", 32'(TimeoutErr), 32'h0);
         if (k == 16) begin
            check("to_pulse",  32'(TimeoutErr), 32'h1);
            check("to_bitcnt", 32'(BitCnt),     32'h0);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("to_once", 32'(TimeoutErr), 32'h0);
      sendWord(8'h0F, 0, 1'b1);
      check("to_next_word", 32'(Word), 32'h0F);

      // Overrun: two words with Ready low
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      sendWord(8'h11, 0, 1'b0);
      sendWord(8'h22, 0, 1'b0);
      check("ovr_word", 32'(Word),    32'h11);
      check("ovr_flag", 32'(Overrun), 32'h1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("ovr_drain",  32'(Valid),   32'h0);
      check("ovr_sticky", 32'(Overrun), 32'h1);

      // Back-to-back words with Ready held high
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      sendWord(8'h55, 0, 1'b1);
      check("b2b_w1", 32'(Word), 32'h55);
      sendWord(8'hAA, 0, 1'b1);
      check("b2b_w2",  32'(Word),    32'hAA);
      check("b2b_ovr", 32'(Overrun), 32'h0);

      // Reset mid-word while a word is held
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("mid_valid",  32'(Valid),  32'h1);
      check("mid_bitcnt", 32'(BitCnt), 32'h5);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      check("mid_rst_word",  32'(Word),   32'h0);
      check("mid_rst_valid", 32'(Valid),  32'h0);
      check("mid_rst_cnt",   32'(BitCnt), 32'h0);
      sendWord(8'hC3, 0, 1'b0);
      check("post_rst_word", 32'(Word), 32'hC3);

      // Randomized traffic with varying bit density
      for (int seg = 0; seg < 80; seg++) begin
         int p;
         case ($urandom_range(0, 3))
            0:       p = 95;
            1:       p = 50;
            2:       p = 10;
            default: p = 2;
         endcase
         for (int c = 0; c < 40; c++) begin
            tick(1'($urandom_range(0, 599) == 0),
                 1'($urandom_range(0, 99) < p),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 60));
         end
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire
